// File: rtl/divremsqrt_intpostproc_pkg.sv
// Shared definitions for the integer divide/remainder post-processor.
// Holds the FSM state enum and the default datapath widths.
package cvw;

  localparam int XLEN_DEF    = 64;
  localparam int DIVB_DEF    = 64;
  localparam int DIVBLEN_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    CORR,
    SHIFT,
    NEG,
    DONE
  } postState_t;

endpackage

// File: rtl/divremsqrt_intnegsel.sv
// Conditional two's-complement negate with optional W64 sign-extend.
// Ports: x in, neg select, w64 select, y out. Macro: DIVREMSQRT_INTPOST_W64_EN.
module divremsqrt_intnegsel import cvw::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] x,
  input  logic            neg,
  input  logic            w64,
  output logic [XLEN-1:0] y
);

  logic [XLEN-1:0] xn;

  assign xn = neg ? -x : x;

`ifdef DIVREMSQRT_INTPOST_W64_EN
  if (XLEN == 64) begin : g_w64
    assign y = w64 ? {{(XLEN-32){xn[31]}}, xn[31:0]}
                   : xn;
  end else begin : g_nw64
    logic unusedW64;
    assign unusedW64 = w64;
    assign y = xn;
  end
`else
  logic unusedW64;
  assign unusedW64 = w64;
  assign y = xn;
`endif

endmodule

// File: rtl/divremsqrt_intpostproc.sv
// Integer div/rem post-processing: residual sum, correction, shift, negate.
// Ports: in_valid/in_ready accept, out_valid/out_ready result handshake.
// Macro: DIVREMSQRT_INTPOST_W64_EN enables 32-bit W64 sign-extension.
module divremsqrt_intpostproc import cvw::*; #(
  parameter int XLEN    = XLEN_DEF,
  parameter int DIVB    = DIVB_DEF,
  parameter int DIVBLEN = DIVBLEN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIVB+3:0]    WS,
  input  logic [DIVB+3:0]    WC,
  input  logic [DIVB+3:0]    D,
  input  logic [DIVB:0]      U,
  input  logic [DIVB:0]      UM,
  input  logic [DIVBLEN-1:0] NormShift,
  input  logic               RemOp,
  input  logic               W64,
  input  logic               As,
  input  logic               Bs,
  input  logic               BZero,
  input  logic               ALTB,
  input  logic [XLEN-1:0]    A,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    Result
);

  postState_t state, nextState;

  logic [DIVB+3:0]    wsR, wcR, dR, w, r, sumW;
  logic [DIVB:0]      uR, umR, q;
  logic [DIVBLEN-1:0] shR;
  logic               remOpR, asR, bsR, wNeg;
  logic [XLEN-1:0]    qSh, rSh;
  logic [XLEN-1:0]    specVal, specRes;
  logic [XLEN-1:0]    negIn, negRes;
  logic               negSel, accept, special;
  logic               w64Sel, w64In;

  assign accept  = in_valid & in_ready;
  assign special = BZero | ALTB;
  assign sumW    = wsR + wcR;

`ifdef DIVREMSQRT_INTPOST_W64_EN
  logic w64R;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)    w64R <= 1'b0;
    else if (accept) w64R <= W64;
  assign w64Sel = w64R;
  assign w64In  = W64;
`else
  logic unusedW64;
  assign unusedW64 = W64;
  assign w64Sel    = 1'b0;
  assign w64In     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nextState;

  // next state
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (in_valid)
               nextState = special ? DONE : SUM;
      SUM:   nextState = CORR;
      CORR:  nextState = SHIFT;
      SHIFT: nextState = NEG;
      NEG:   nextState = DONE;
      DONE:  if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // divide-by-zero gives all ones, A<B gives zero quotient
  assign specVal = RemOp ? A
                 : (BZero ? {XLEN{1'b1}} : '0);

  assign negIn  = remOpR ? rSh : qSh;
  assign negSel = remOpR ? asR : (asR ^ bsR);

  divremsqrt_intnegsel #(.XLEN(XLEN)) uNeg (
    .x   (negIn),
    .neg (negSel),
    .w64 (w64Sel),
    .y   (negRes)
  );

  divremsqrt_intnegsel #(.XLEN(XLEN)) uSpec (
    .x   (specVal),
    .neg (1'b0),
    .w64 (w64In),
    .y   (specRes)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsR    <= '0;
      wcR    <= '0;
      dR     <= '0;
      uR     <= '0;
      umR    <= '0;
      shR    <= '0;
      remOpR <= 1'b0;
      asR    <= 1'b0;
      bsR    <= 1'b0;
      w      <= '0;
      wNeg   <= 1'b0;
      q      <= '0;
      r      <= '0;
      qSh    <= '0;
      rSh    <= '0;
      Result <= '0;
    end else begin
      if (accept) begin
        wsR    <= WS;
        wcR    <= WC;
        dR     <= D;
        uR     <= U;
        umR    <= UM;
        shR    <= NormShift;
        remOpR <= RemOp;
        asR    <= As;
        bsR    <= Bs;
        if (special) Result <= specRes;
      end
      if (state == SUM) begin
        w    <= sumW;
        wNeg <= sumW[DIVB+3];
      end
      // negative residual: quotient overshot by one
      if (state == CORR) begin
        q <= wNeg ? umR : uR;
        r <= wNeg ? (w + dR) : w;
      end
      if (state == SHIFT) begin
        qSh <= XLEN'(q >> shR);
        rSh <= XLEN'($signed(r) >>> shR);
      end
      if (state == NEG) Result <= negRes;
    end
  end

endmodule

// File: tb/tb_divremsqrt_intpostproc.sv
// Self-checking bench for divremsqrt_intpostproc (XLEN=64 defaults).
// Directed cases followed by randomized ops against a reference model.
module tb_divremsqrt_intpostproc;

  typedef struct {
    logic [67:0] ws, wc, d;
    logic [64:0] u, um;
    logic [6:0]  sh;
    logic        remOp, w64, as, bs, bz, altb;
    logic [63:0] a;
  } op_t;

  logic        clk = 0;
  logic        resetN = 0;
  logic        inValid = 0;
  logic        inReady;
  logic [67:0] ws = '0, wc = '0, d = '0;
  logic [64:0] u = '0, um = '0;
  logic [6:0]  sh = '0;
  logic        remOp = 0, w64 = 0, as = 0, bs = 0;
  logic        bz = 0, altb = 0;
  logic [63:0] a = '0;
  logic        outValid;
  logic        outReady = 0;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divremsqrt_intpostproc dut (
    .clk       (clk),
    .reset_n   (resetN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .WS        (ws),
    .WC        (wc),
    .D         (d),
    .U         (u),
    .UM        (um),
    .NormShift (sh),
    .RemOp     (remOp),
    .W64       (w64),
    .As        (as),
    .Bs        (bs),
    .BZero     (bz),
    .ALTB      (altb),
    .A         (a),
    .out_valid (outValid),
    .out_ready (outReady),
    .Result    (result)
  );

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refModel(op_t o);
    logic [63:0]        res;
    logic signed [67:0] w, rem;
    logic [64:0]        quo;
    if (o.bz)        res = o.remOp ? o.a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (o.altb) res = o.remOp ? o.a : 64'h0;
    else begin
      w   = o.ws + o.wc;
      quo = w[67] ? o.um : o.u;
      rem = w[67] ? w + o.d : w;
      quo = quo >> o.sh;
      rem = rem >>> o.sh;
      res = o.remOp ? rem[63:0] : quo[63:0];
      if (o.remOp ? o.as : (o.as ^ o.bs)) res = -res;
    end
`ifdef DIVREMSQRT_INTPOST_W64_EN
    if (o.w64) res = {{32{res[31]}}, res[31:0]};
`endif
    return res;
  endfunction

  function automatic op_t randOp();
    op_t o;
    o.ws    = {$urandom, $urandom, $urandom};
    o.wc    = {$urandom, $urandom, $urandom};
    o.d     = {$urandom, $urandom, $urandom};
    o.u     = {$urandom, $urandom, $urandom};
    o.um    = {$urandom, $urandom, $urandom};
    o.sh    = 7'($urandom_range(0, 100));
    o.remOp = 1'($urandom);
    o.w64   = 1'($urandom);
    o.as    = 1'($urandom);
    o.bs    = 1'($urandom);
    o.bz    = ($urandom_range(0, 7) == 0);
    o.altb  = ($urandom_range(0, 7) == 0);
    o.a     = {$urandom, $urandom};
    return o;
  endfunction

  function automatic op_t mkOp(logic [67:0] wsv,
      logic [64:0] uv, logic rop, logic asv, logic bsv,
      logic bzv, logic altbv, logic [63:0] av, logic w64v);
    op_t o;
    o.ws = wsv;  o.wc = '0;  o.d = 68'd7;
    o.u = uv;  o.um = uv - 65'd1;  o.sh = '0;
    o.remOp = rop;  o.w64 = w64v;  o.as = asv;
    o.bs = bsv;  o.bz = bzv;  o.altb = altbv;  o.a = av;
    return o;
  endfunction

  task automatic drive(op_t o);
    ws = o.ws;  wc = o.wc;  d = o.d;  u = o.u;  um = o.um;
    sh = o.sh;  remOp = o.remOp;  w64 = o.w64;  as = o.as;
    bs = o.bs;  bz = o.bz;  altb = o.altb;  a = o.a;
  endtask

  // accept, scramble inputs while busy, wait, hold, drain
  task automatic runOp(string tag, op_t o, logic [63:0] exp,
                       int hold);
    int n;
    int lat;
    lat = (o.bz || o.altb) ? 0 : 4;
    drive(o);
    inValid = 1;
    check({tag, "_inrdy"}, 64'(inReady), 64'd1);
    @(posedge clk); #1;
    drive(randOp());
    n = 0;
    while (!outValid && n < 10) begin
      check({tag, "_busy"}, 64'(inReady), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    inValid = 0;
    check({tag, "_lat"}, 64'(n), 64'(lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_holdv"}, 64'(outValid), 64'd1);
      check({tag, "_holdr"}, 64'(inReady), 64'd0);
      check({tag, "_holdq"}, result, exp);
    end
    check({tag, "_res"}, result, exp);
    outReady = 1;
    @(posedge clk); #1;
    outReady = 0;
    check({tag, "_idle"}, 64'(inReady), 64'd1);
    check({tag, "_ovlo"}, 64'(outValid), 64'd0);
  endtask

  initial begin
    op_t o;
    #12;
    check("rst_rdy", 64'(inReady), 64'd1);
    check("rst_ov", 64'(outValid), 64'd0);
    check("rst_res", result, 64'd0);
    resetN = 1;
    #2;

    // 100/7 quotient 14 remainder 2
    o = mkOp(68'd2, 65'd14, 0, 0, 0, 0, 0, 64'd100, 0);
    runOp("div100_7", o, 64'd14, 0);

    o = mkOp(68'd2, 65'd14, 1, 1, 0, 0, 0,
             64'hFFFF_FFFF_FFFF_FF9C, 0);
    runOp("remneg", o, 64'hFFFF_FFFF_FFFF_FFFE, 1);

    o = mkOp(68'd0, 65'd0, 0, 0, 0, 1, 0, 64'd5, 0);
    runOp("divu_bz", o, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    o.remOp = 1;
    runOp("remu_bz", o, 64'd5, 0);

    o = mkOp(68'd0, 65'd0, 0, 0, 0, 0, 1, 64'd3, 0);
    runOp("altb_div", o, 64'd0, 0);
    o.remOp = 1;
    runOp("altb_rem", o, 64'd3, 0);

    // BZero wins over ALTB
    o = mkOp(68'd0, 65'd0, 0, 0, 0, 1, 1, 64'd3, 0);
    runOp("bz_prio", o, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    o = mkOp(68'd0, 65'd4, 0, 1, 0, 0, 0,
             64'hFFFF_FFFF_FFFF_FFF8, 1);
    runOp("divw", o, 64'hFFFF_FFFF_FFFF_FFFC, 3);

    // negative residual selects UM and W+D
    o = mkOp({4'hF, 64'hFFFF_FFFF_FFFF_FFFB}, 65'd15,
             0, 0, 0, 0, 0, 64'd100, 0);
    runOp("corr_q", o, refModel(o), 0);
    o.remOp = 1;
    runOp("corr_r", o, refModel(o), 0);

    // reset pulse while in SHIFT
    o = mkOp(68'd2, 65'd14, 0, 0, 0, 0, 0, 64'd100, 0);
    drive(o);
    inValid = 1;
    @(posedge clk); #1;
    inValid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetN = 0;
    #2;
    check("midrst_rdy", 64'(inReady), 64'd1);
    check("midrst_ov", 64'(outValid), 64'd0);
    check("midrst_res", result, 64'd0);
    #2;
    resetN = 1;
    #1;
    runOp("post_rst", o, 64'd14, 0);

    for (int i = 0; i < 40; i++) begin
      o = randOp();
      runOp($sformatf("rnd%0d", i), o, refModel(o),
            $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
